ifu_line_queue: RTL and testbench

Parametrised successor of the single-instruction fetch unit. It owns the sequential fetch PC and requests whole i-cache lines. Each returned line is unpacked in one cycle into a QUEUE_DEPTH-entry instruction queue, starting at the PC's word offset. Decode drains the queue over a valid/ready handshake. It sits between the redirect/branch logic and the i-cache interface on one side, and instruction decode on the other.

---
 rtl/ifu_line_queue.sv | 128 ++++++++++++
 tb/tb_ifu_line_queue.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_line_queue.sv
// Line-based instruction fetch unit: requests whole i-cache lines and unpacks them into a
// circular instruction queue drained by decode. Define IFU_PERF_CNT_EN to add perf counters.
module ifu_line_queue #(
  parameter int unsigned    XLEN        = 32,
  parameter int unsigned    ILEN        = 32,
  parameter int unsigned    LINE_INSTR  = 4,
  parameter int unsigned    QUEUE_DEPTH = 8,
  parameter logic [XLEN-1:0] BOOT_PC    = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic                       read_req_o,
  output logic [XLEN-1:0]            read_addr_o,
  input  logic                       read_done_i,
  input  logic [LINE_INSTR*ILEN-1:0] line_i,
  input  logic                       issue_ready_i,
  output logic                       issue_valid_o,
  output logic [ILEN-1:0]            instruction_o,
  output logic [XLEN-1:0]            instr_pc_o
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]                stall_cnt_o,
  output logic [31:0]                line_cnt_o
`endif
);

  localparam int unsigned OFS_W = $clog2(LINE_INSTR);
  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [XLEN-1:0] LINE_MASK = ~XLEN'(LINE_INSTR * 4 - 1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

  state_e            state_q;
  logic [XLEN-1:0]   fetch_pc_q;
  logic [XLEN-1:0]   drain_addr_q;
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  logic [ILEN-1:0]   instr_mem [QUEUE_DEPTH];
  logic [XLEN-1:0]   pc_mem    [QUEUE_DEPTH];

  logic [XLEN-1:0]   line_base;
  logic [OFS_W-1:0]  line_ofs;
  logic              push_en;
  logic              pop_en;
  logic              has_space;
  logic [CNT_W-1:0]  push_cnt;

  assign line_base = fetch_pc_q & LINE_MASK;
  assign line_ofs  = fetch_pc_q[OFS_W+1:2];

  // A flush wins over both ends of the queue; data returning with it is dropped.
  assign push_en   = (state_q == REQ) && read_done_i && !flush_i;
  assign pop_en    = issue_valid_o && issue_ready_i && !flush_i;
  assign push_cnt  = push_en ? (CNT_W'(LINE_INSTR) - CNT_W'(line_ofs)) : '0;
  assign has_space = count_q <= CNT_W'(QUEUE_DEPTH - LINE_INSTR);

  assign read_req_o    = (state_q != IDLE);
  // While draining, fetch_pc already holds the redirect target, so the old address is kept apart.
  assign read_addr_o   = (state_q == DRAIN) ? drain_addr_q : line_base;
  assign issue_valid_o = (count_q != '0);
  assign instruction_o = issue_valid_o ? instr_mem[head_q] : '0;
  assign instr_pc_o    = issue_valid_o ? pc_mem[head_q]    : '0;

  // NOTE: queue storage has no reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      for (int k = 0; k < int'(LINE_INSTR); k++) begin
        if (k >= int'(line_ofs)) begin
          instr_mem[tail_q + PTR_W'(k) - PTR_W'(line_ofs)] <= line_i[k*ILEN +: ILEN];
          pc_mem[tail_q + PTR_W'(k) - PTR_W'(line_ofs)]    <= line_base + XLEN'(4 * k);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      fetch_pc_q   <= BOOT_PC;
      drain_addr_q <= BOOT_PC & LINE_MASK;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
    end else if (flush_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= redirect_pc_i;
      if (state_q == REQ) drain_addr_q <= line_base;
      // An open cache transaction must still be completed before a new one can start.
      if (state_q != IDLE && !read_done_i) state_q <= DRAIN;
      else                                 state_q <= IDLE;
    end else begin
      if (pop_en)  head_q <= head_q + 1'b1;
      if (push_en) tail_q <= tail_q + PTR_W'(push_cnt);
      count_q <= count_q - CNT_W'(pop_en) + push_cnt;
      case (state_q)
        IDLE:  if (has_space) state_q <= REQ;
        REQ: begin
          if (read_done_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= line_base + XLEN'(LINE_INSTR * 4);
          end
        end
        DRAIN: if (read_done_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
      line_cnt_o  <= '0;
    end else begin
      if (issue_ready_i && !issue_valid_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (push_en && line_cnt_o != '1)                         line_cnt_o  <= line_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_line_queue.sv
// Bench for ifu_line_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_ifu_line_queue;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int LI   = 4;
  localparam int QD   = 8;
  localparam int LW   = LI * ILEN;
  localparam logic [31:0] BOOT = 32'h100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [31:0]   rpc = '0;
  logic          read_req;
  logic [31:0]   read_addr;
  logic          done = 1'b0;
  logic [LW-1:0] line = '0;
  logic          ready = 1'b0;
  logic          valid;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
`ifdef IFU_PERF_CNT_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   line_cnt;
`endif

  always #5 clk = ~clk;

  ifu_line_queue #(
    .XLEN(XLEN), .ILEN(ILEN), .LINE_INSTR(LI), .QUEUE_DEPTH(QD), .BOOT_PC(BOOT)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .flush_i(flush),
    .redirect_pc_i(rpc),
    .read_req_o(read_req),
    .read_addr_o(read_addr),
    .read_done_i(done),
    .line_i(line),
    .issue_ready_i(ready),
    .issue_valid_o(valid),
    .instruction_o(instr),
    .instr_pc_o(instr_pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .stall_cnt_o(stall_cnt),
    .line_cnt_o(line_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: instruction/PC queues plus "a line request is outstanding" flags.
  logic [31:0] m_instr[$];
  logic [31:0] m_pc[$];
  logic [31:0] m_fetch;
  logic [31:0] m_req_addr;
  bit          m_busy;
  bit          m_discard;
  logic [31:0] m_stall;
  logic [31:0] m_lines;
  int          lat = -1;

  function automatic logic [31:0] base_of(input logic [31:0] a);
    return a & ~32'(LI * 4 - 1);
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LI; i++) l[i*ILEN +: ILEN] = $urandom;
    return l;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    bit ne;
    ne = (m_pc.size() != 0);
    check("read_req",    read_req,  m_busy);
    check("read_addr",   read_addr, m_busy ? m_req_addr : base_of(m_fetch));
    check("issue_valid", valid,     ne);
    check("instruction", instr,     ne ? m_instr[0] : 32'h0);
    check("instr_pc",    instr_pc,  ne ? m_pc[0] : 32'h0);
`ifdef IFU_PERF_CNT_EN
    check("stall_cnt",   stall_cnt, m_stall);
    check("line_cnt",    line_cnt,  m_lines);
`endif
  endtask

  task automatic model_step(input bit f, input logic [31:0] rp, input bit d,
                            input logic [LW-1:0] ln, input bit rdy);
    bit pop;
    bit room;
    int ofs;
    pop  = (m_pc.size() != 0) && rdy;
    room = (QD - m_pc.size()) >= LI;
    if (rdy && m_pc.size() == 0) m_stall++;
    if (f) begin
      m_instr.delete();
      m_pc.delete();
      m_fetch = rp;
      if (m_busy && !d) m_discard = 1;
      else begin
        m_busy    = 0;
        m_discard = 0;
      end
    end else begin
      if (pop) begin
        void'(m_instr.pop_front());
        void'(m_pc.pop_front());
      end
      if (m_busy) begin
        if (d) begin
          if (!m_discard) begin
            ofs = int'((m_fetch / 4) % LI);
            for (int k = ofs; k < LI; k++) begin
              m_instr.push_back(ln[k*ILEN +: ILEN]);
              m_pc.push_back(base_of(m_fetch) + 32'(4 * k));
            end
            m_fetch = base_of(m_fetch) + 32'(LI * 4);
            m_lines++;
          end
          m_busy    = 0;
          m_discard = 0;
        end
      end else if (room) begin
        m_busy     = 1;
        m_req_addr = base_of(m_fetch);
      end
    end
  endtask

  // Called at a negedge: drive one cycle of inputs, advance model, compare after the edge.
  task automatic step(input bit f, input logic [31:0] rp, input bit d,
                      input logic [LW-1:0] ln, input bit rdy);
    flush = f;
    rpc   = rp;
    done  = d;
    line  = ln;
    ready = rdy;
    model_step(f, rp, d, ln, rdy);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    done  = 1'b0;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    done  = 1'b0;
    ready = 1'b0;
    line  = '0;
    rpc   = '0;
    m_instr.delete();
    m_pc.delete();
    m_fetch   = BOOT;
    m_busy    = 0;
    m_discard = 0;
    m_stall   = '0;
    m_lines   = '0;
    lat       = -1;
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [LW-1:0] l;
    bit f;
    bit d;
    bit rdy;
    logic [31:0] rp;

    do_reset();
    check("rst read_req", read_req, 1'b0);
    check("rst read_addr", read_addr, 32'h100);
    check("rst valid", valid, 1'b0);
    check("rst instr", instr, 32'h0);
    check("rst pc", instr_pc, 32'h0);

    // Boot fetch, 1-cycle cache, decode always ready
    step(0, '0, 0, '0, 1);
    check("t1 req", read_req, 1'b1);
    check("t1 addr", read_addr, 32'h100);
    l = rand_line();
    step(0, '0, 1, l, 1);
    check("t1 pc0", instr_pc, 32'h100);
    check("t1 instr0", instr, l[31:0]);
    check("t1 req low", read_req, 1'b0);
    step(0, '0, 0, '0, 1);
    check("t1 pc1", instr_pc, 32'h104);
    check("t1 next addr", read_addr, 32'h110);
    check("t1 next req", read_req, 1'b1);
    step(0, '0, 1, rand_line(), 1);
    check("t1 pc2", instr_pc, 32'h108);
    step(0, '0, 0, '0, 1);
    check("t1 pc3", instr_pc, 32'h10C);

    // Redirect into the middle of a line
    step(1, 32'h208, 0, '0, 1);
    check("t2 valid after flush", valid, 1'b0);
    step(0, '0, 0, '0, 1);
    check("t2 req addr", read_addr, 32'h200);
    l = rand_line();
    step(0, '0, 1, l, 1);
    check("t2 pc0", instr_pc, 32'h208);
    check("t2 instr0", instr, l[95:64]);
    step(0, '0, 0, '0, 1);
    check("t2 pc1", instr_pc, 32'h20C);
    check("t2 next addr", read_addr, 32'h210);
    step(0, '0, 1, rand_line(), 1);

    // Back-pressure: queue fills and requests stop until a full line fits
    step(1, 32'h300, 0, '0, 0);
    step(0, '0, 0, '0, 0);
    step(0, '0, 1, rand_line(), 0);
    step(0, '0, 0, '0, 0);
    step(0, '0, 1, rand_line(), 0);
    step(0, '0, 0, '0, 0);
    step(0, '0, 0, '0, 0);
    check("t3 full no req", read_req, 1'b0);
    check("t3 head pc", instr_pc, 32'h300);
    for (int i = 0; i < 3; i++) step(0, '0, 0, '0, 1);
    check("t3 free3 no req", read_req, 1'b0);
    check("t3 head after 3", instr_pc, 32'h30C);
    step(0, '0, 0, '0, 1);
    check("t3 free4 not yet", read_req, 1'b0);
    step(0, '0, 0, '0, 0);
    check("t3 req issues", read_req, 1'b1);
    check("t3 req addr", read_addr, 32'h320);

    // Flush during an open request with a slow cache
    step(1, 32'h400, 0, '0, 0);
    check("t4 req held", read_req, 1'b1);
    check("t4 addr held", read_addr, 32'h320);
    check("t4 empty", valid, 1'b0);
    step(0, '0, 0, '0, 0);
    step(0, '0, 0, '0, 0);
    check("t4 addr still held", read_addr, 32'h320);
    step(0, '0, 1, rand_line(), 0);
    check("t4 discarded", valid, 1'b0);
    check("t4 idle", read_req, 1'b0);
    step(0, '0, 0, '0, 0);
    check("t4 new req", read_addr, 32'h400);
    check("t4 new req hi", read_req, 1'b1);

    // Flush coinciding with read_done and a pop
    step(0, '0, 1, rand_line(), 0);
    step(0, '0, 0, '0, 1);
    check("t5 in req", read_req, 1'b1);
    check("t5 head", instr_pc, 32'h404);
    step(1, 32'h504, 1, rand_line(), 1);
    check("t5 empty", valid, 1'b0);
    check("t5 idle", read_req, 1'b0);
    check("t5 fetch base", read_addr, 32'h500);
    step(0, '0, 0, '0, 1);
    check("t5 req addr", read_addr, 32'h500);
    l = rand_line();
    step(0, '0, 1, l, 0);
    check("t5 offset pc", instr_pc, 32'h504);
    check("t5 offset instr", instr, l[63:32]);

    // Randomized traffic, including redirects near the top of the address space
    for (int n = 0; n < 4000; n++) begin
      f = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 3))
        0:       rp = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: rp = $urandom;
      endcase
      d = 0;
      if (m_busy) begin
        if (lat < 0) lat = $urandom_range(0, 3);
        d = (lat == 0);
        if (d) lat = -1;
        else   lat--;
      end
      rdy = (n < 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step(f, rp, d, rand_line(), rdy);
    end

`ifdef IFU_PERF_CNT_EN
    // Counters with a 5-cycle cache after a fresh reset
    do_reset();
    step(0, '0, 0, '0, 1);
    for (int i = 0; i < 5; i++) step(0, '0, 0, '0, 1);
    step(0, '0, 1, rand_line(), 1);
    check("t6 first issue", valid, 1'b1);
    check("t6 stall>=6", stall_cnt >= 32'd6, 1'b1);
    check("t6 one line", line_cnt, 32'd1);
    step(0, '0, 0, '0, 1);
    step(1, 32'h700, 1, rand_line(), 1);
    check("t6 discarded not counted", line_cnt, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
